alu_seq_nbit: RTL and testbench
===============================

Name: alu_seq_nbit

Overview:
Parametrised, clocked successor to the combinational 16-bit ALU.
- Operands and opcode are captured on a start pulse.
- Add, subtract, logic and shift complete in one cycle.
- Multiply (shift-add) and divide/modulo (restoring) are iterative, taking WIDTH cycles.
- A one-cycle done pulse accompanies a registered result and NZCV flags, so the block sits directly on the lab datapath/FSM bus.

Parameters:
WIDTH, 16, operand/result width in bits (must be ≥4). SHW = $clog2(WIDTH) is derived internally.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
a  in  WIDTH  operand A (unsigned for mul/div)
b  in  WIDTH  operand B / shift amount
op  in  4  opcode
busy  out  1  high from capture until done
done  out  1  one-cycle pulse; result and flags valid from this cycle
result  out  WIDTH  registered result, held until next done
NFlag  out  1  result[WIDTH-1]
ZFlag  out  1  result == 0
CFlag  out  1  carry / no-borrow / shifted-out bit / mul overflow
VFlag  out  1  signed overflow / divide-by-zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, NFlag, ZFlag, CFlag and VFlag all 0; iteration counter 0. Reset mid-operation aborts it, and no done is issued.
- States: IDLE, EXEC, ITER, FIN.
  - IDLE→EXEC on start=1 at edge k; a, b and op are latched there. Later input changes are ignored.
  - EXEC: 1-cycle ops write result/flags and go to FIN. Mul/div/mod load the iterator and go to ITER.
  - ITER: runs exactly WIDTH cycles (counter WIDTH-1 down to 0), then goes to FIN.
  - FIN: done=1 for one cycle, then IDLE. busy=1 in EXEC, ITER and FIN.
- Latency from start edge k: 1-cycle ops assert done after edge k+2. Mul/div/mod assert done after edge k+WIDTH+2.
- Back-to-back: start seen in the IDLE cycle right after FIN is accepted. start while busy is ignored and not queued.
- Opcodes:
  - 0001 ADD: C = carry out; V = signed overflow.
  - 0010 SUB: a-b; C = 1 when a ≥ b unsigned (no borrow); V = signed overflow.
  - 0011 MUL: low WIDTH bits of the unsigned product; C = 1 if the high half ≠ 0; V = 0.
  - 0100 DIV: unsigned a/b. 0110 MOD: a%b, unsigned. For both, C = 0.
    - b=0: DIV gives all ones, MOD gives a. V = 1 in both cases.
    - Divide-by-zero still takes the full WIDTH iterations.
  - 0101 AND, 0111 OR, 1000 XOR: C = 0, V = 0.
  - 1001 SHL, 1011 SHR (logical): shift amount = b.
    - b ≥ WIDTH: result 0; C = a[0] for SHL, a[WIDTH-1] for SHR when b = WIDTH, else 0.
    - Otherwise C = last bit shifted out; b=0 gives C = 0. V = 0.
  - Any other op: result 0, C = 0, V = 0; still 1-cycle with done.
- N and Z always derive from the final result. All outputs change only on a clock edge or reset.

Test Plan:
1. WIDTH=16, ADD a=0x7FFF b=0x0001, start at edge k -> done after edge k+2; result 0x8000, N=1 Z=0 C=0 V=1. SUB 0x0003-0x0003 -> 0x0000, Z=1 C=1 N=0 V=0.
2. MUL a=0x0100 b=0x0100 -> done exactly 18 cycles after start; result 0x0000, Z=1 C=1. A second start pulsed at cycle 5 is ignored: one done, busy stays high throughout.
3. DIV a=0x0064 b=0x0007 -> 0x000E; MOD same operands -> 0x0002. DIV b=0 -> 0xFFFF, V=1. MOD b=0 -> 0x0064, V=1.
4. SHL a=0x8001 b=1 -> 0x0002, C=1. SHR a=0x8001 b=16 -> 0x0000, C=1, Z=1. SHR b=20 -> 0x0000, C=0. XOR 0xF0F0^0xFFFF -> 0x0F0F, N=0.
5. Start MUL; drop rst_n at iteration 7 -> outputs 0 immediately, no done pulse. After release, ADD 2+3 -> 0x0005 with normal latency.
6. WIDTH=8 re-elaboration: ADD 0xFF+0x01 -> 0x00, C=1 Z=1. MUL 0x10*0x10 -> 0x00, C=1, done 10 cycles after start. Unknown op 0xF -> 0x00, Z=1.

Source files
------------

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit -- clocked, parameterised ALU with a start/done handshake.
// Operands and opcode are captured on start. Add, sub, logic and shift
// operations finish in one execute cycle. Multiply (shift-add) and
// divide/modulo (restoring) iterate for WIDTH cycles. done pulses for one
// cycle alongside a registered result and NZCV flags.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           request, sampled only while idle
//   a, b            operands (b is also the shift amount)
//   op              4-bit opcode
//   busy            high from capture until done
//   done            one-cycle completion pulse
//   result          registered result, held until the next done
//   NFlag..VFlag    registered flags that go with result
module alu_seq_nbit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             NFlag,
  output logic             ZFlag,
  output logic             CFlag,
  output logic             VFlag
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1011;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [SHW-1:0]     cnt;
  logic               done_nxt;
  logic               is_iter;

  // iteration state: mul uses acc/mcand/q (q = multiplier),
  // div/mod use rem/q (q = dividend shifting out, quotient shifting in)
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]   q, q_nxt, rem, rem_nxt, rem_diff;
  logic [WIDTH:0]     rem_sh;
  logic               ge;

  // single-cycle datapath
  logic [WIDTH:0]     sum, dif, shl, shr;
  logic [WIDTH-1:0]   res1;
  logic               c1, v1;

  // result write port
  logic               wr_en, wr_c, wr_v;
  logic [WIDTH-1:0]   wr_res;

  assign is_iter = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)       state_nxt = EXEC;
      EXEC: state_nxt = is_iter ? ITER : FIN;
      ITER: if (cnt == '0)   state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // done is registered off FIN so it lands one edge after the result.
  always_comb begin
    busy     = (state != IDLE);
    done_nxt = (state == FIN);
  end

  // ---------------- single-cycle ops ----------------
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};
  // One extra bit catches the last bit shifted out. Shifts by >= WIDTH+1
  // clear everything; a shift of exactly WIDTH leaves the edge bit in it.
  assign shl = {1'b0, a_q} << b_q;
  assign shr = {a_q, 1'b0} >> b_q;

  always_comb begin
    res1 = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res1 = sum[WIDTH-1:0];
        c1   = sum[WIDTH];
        v1   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res1 = dif[WIDTH-1:0];
        c1   = ~dif[WIDTH];
        v1   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res1 = a_q & b_q;
      OP_OR:  res1 = a_q | b_q;
      OP_XOR: res1 = a_q ^ b_q;
      OP_SHL: begin
        res1 = shl[WIDTH-1:0];
        c1   = shl[WIDTH];
      end
      OP_SHR: begin
        res1 = shr[WIDTH:1];
        c1   = shr[0];
      end
      default: ;
    endcase
  end

  // ---------------- iterative step ----------------
  assign acc_nxt   = acc + (q[0] ? mcand : '0);
  assign mcand_nxt = mcand << 1;

  // Restoring division. With b = 0 the compare always succeeds, so the
  // quotient fills with ones and the remainder ends up equal to a.
  assign rem_sh   = {rem, q[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, b_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - b_q;
  assign rem_nxt  = ge ? rem_diff : rem_sh[WIDTH-1:0];
  assign q_nxt    = (op_q == OP_MUL) ? (q >> 1) : {q[WIDTH-2:0], ge};

  // ---------------- result write select ----------------
  always_comb begin
    wr_en  = 1'b0;
    wr_res = res1;
    wr_c   = c1;
    wr_v   = v1;
    if (state == EXEC && !is_iter) begin
      wr_en = 1'b1;
    end else if (state == ITER && cnt == '0) begin
      wr_en = 1'b1;
      case (op_q)
        OP_MUL: begin
          wr_res = acc_nxt[WIDTH-1:0];
          wr_c   = |acc_nxt[2*WIDTH-1:WIDTH];
          wr_v   = 1'b0;
        end
        OP_DIV: begin
          wr_res = q_nxt;
          wr_c   = 1'b0;
          wr_v   = (b_q == '0);
        end
        default: begin
          wr_res = rem_nxt;
          wr_c   = 1'b0;
          wr_v   = (b_q == '0);
        end
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      q      <= '0;
      rem    <= '0;
      done   <= 1'b0;
      result <= '0;
      NFlag  <= 1'b0;
      ZFlag  <= 1'b0;
      CFlag  <= 1'b0;
      VFlag  <= 1'b0;
    end else begin
      done <= done_nxt;
      if (state == IDLE && start) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (state == EXEC && is_iter) begin
        cnt   <= SHW'(WIDTH - 1);
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, a_q};
        rem   <= '0;
        q     <= (op_q == OP_MUL) ? b_q : a_q;
      end
      if (state == ITER) begin
        cnt   <= cnt - SHW'(1);
        acc   <= acc_nxt;
        mcand <= mcand_nxt;
        rem   <= rem_nxt;
        q     <= q_nxt;
      end
      if (wr_en) begin
        result <= wr_res;
        NFlag  <= wr_res[WIDTH-1];
        ZFlag  <= (wr_res == '0);
        CFlag  <= wr_c;
        VFlag  <= wr_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit: a 16-bit and an 8-bit instance share
// clock and reset. Expected values are hand-computed constants.
module tb_alu_seq_nbit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [3:0]  op16, op8;
  logic        busy16, done16, n16, z16, c16, v16;
  logic        busy8, done8, n8, z8, c8, v8;
  logic [15:0] res16;
  logic [7:0]  res8;

  int n_cmp = 0;
  int n_err = 0;
  int lat, extra, busy_bad;

  always #5 clk = ~clk;

  alu_seq_nbit #(.WIDTH(16)) d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .op(op16),
    .busy(busy16), .done(done16), .result(res16),
    .NFlag(n16), .ZFlag(z16), .CFlag(c16), .VFlag(v16));

  alu_seq_nbit #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .op(op8),
    .busy(busy8), .done(done8), .result(res8),
    .NFlag(n8), .ZFlag(z8), .CFlag(c8), .VFlag(v8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, scramble the inputs afterwards (they must
  // have been latched), then count edges until done shows up.
  task automatic run(input bit w8, input logic [3:0] o, input logic [15:0] x,
                     input logic [15:0] y, output int l);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; op8 = o; end
    else    begin start16 = 1'b1; a16 = x; b16 = y; op16 = o; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    a16 = ~x; b16 = ~y; op16 = ~o;
    a8 = ~x[7:0]; b8 = ~y[7:0]; op8 = ~o;
    l = 0;
    while (!(w8 ? done8 : done16) && l < 40) begin
      @(posedge clk); #1; l++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start16 = 1'b0; start8 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0;
    a8 = '0; b8 = '0; op8 = '0;

    // reset state
    #7;
    chk("rst16_out", {busy16, done16, n16, z16, c16, v16, res16}, 32'h0);
    chk("rst8_out",  {busy8, done8, n8, z8, c8, v8, res8}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // ADD overflow
    run(0, 4'b0001, 16'h7FFF, 16'h0001, lat);
    chk("add_lat", lat, 2);
    chk("add_res", res16, 16'h8000);
    chk("add_nzcv", {n16, z16, c16, v16}, 4'b1001);
    chk("add_busy_at_done", busy16, 1'b0);
    @(posedge clk); #1;
    chk("add_done_pulse", done16, 1'b0);

    // SUB equal operands
    run(0, 4'b0010, 16'h0003, 16'h0003, lat);
    chk("sub_res", res16, 16'h0000);
    chk("sub_nzcv", {n16, z16, c16, v16}, 4'b0110);

    // MUL with an ignored second start at cycle 5
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0100; b16 = 16'h0100; op16 = 4'b0011;
    @(posedge clk); #1;
    start16 = 1'b0; op16 = 4'b0001;
    lat = 0; busy_bad = 0;
    while (!done16 && lat < 40) begin
      if (!busy16) busy_bad++;
      start16 = (lat == 4);
      @(posedge clk); #1; lat++;
    end
    start16 = 1'b0;
    chk("mul_lat", lat, 18);
    chk("mul_busy_held", busy_bad, 0);
    chk("mul_res", res16, 16'h0000);
    chk("mul_nzcv", {n16, z16, c16, v16}, 4'b0110);
    extra = 0; busy_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done16) extra++;
      if (busy16) busy_bad++;
    end
    chk("mul_no_queued_done", extra, 0);
    chk("mul_no_queued_busy", busy_bad, 0);

    // DIV / MOD
    run(0, 4'b0100, 16'h0064, 16'h0007, lat);
    chk("div_lat", lat, 18);
    chk("div_res", res16, 16'h000E);
    chk("div_nzcv", {n16, z16, c16, v16}, 4'b0000);
    run(0, 4'b0110, 16'h0064, 16'h0007, lat);
    chk("mod_res", res16, 16'h0002);
    run(0, 4'b0100, 16'h0064, 16'h0000, lat);
    chk("div0_lat", lat, 18);
    chk("div0_res", res16, 16'hFFFF);
    chk("div0_nzcv", {n16, z16, c16, v16}, 4'b1001);
    run(0, 4'b0110, 16'h0064, 16'h0000, lat);
    chk("mod0_res", res16, 16'h0064);
    chk("mod0_nzcv", {n16, z16, c16, v16}, 4'b0001);

    // shifts and logic
    run(0, 4'b1001, 16'h8001, 16'd1, lat);
    chk("shl_lat", lat, 2);
    chk("shl_res", res16, 16'h0002);
    chk("shl_nzcv", {n16, z16, c16, v16}, 4'b0010);
    run(0, 4'b1011, 16'h8001, 16'd16, lat);
    chk("shr16_res", res16, 16'h0000);
    chk("shr16_nzcv", {n16, z16, c16, v16}, 4'b0110);
    run(0, 4'b1011, 16'h8001, 16'd20, lat);
    chk("shr20_nzcv", {n16, z16, c16, v16}, 4'b0100);
    run(0, 4'b1011, 16'h8001, 16'd0, lat);
    chk("shr0_res", res16, 16'h8001);
    chk("shr0_nzcv", {n16, z16, c16, v16}, 4'b1000);
    run(0, 4'b1000, 16'hF0F0, 16'hFFFF, lat);
    chk("xor_res", res16, 16'h0F0F);
    chk("xor_nzcv", {n16, z16, c16, v16}, 4'b0000);

    // reset in the middle of a multiply
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0003; b16 = 16'h0005; op16 = 4'b0011;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("midrst_busy_before", busy16, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", {busy16, done16, n16, z16, c16, v16, res16}, 32'h0);
    extra = 0;
    repeat (3) begin @(posedge clk); #1; if (done16 || busy16) extra++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (done16 || busy16) extra++; end
    chk("midrst_no_done", extra, 0);
    run(0, 4'b0001, 16'h0002, 16'h0003, lat);
    chk("post_rst_add_lat", lat, 2);
    chk("post_rst_add_res", res16, 16'h0005);

    // 8-bit instance
    run(1, 4'b0001, 16'h00FF, 16'h0001, lat);
    chk("w8_add_lat", lat, 2);
    chk("w8_add_res", res8, 8'h00);
    chk("w8_add_nzcv", {n8, z8, c8, v8}, 4'b0110);
    run(1, 4'b0011, 16'h0010, 16'h0010, lat);
    chk("w8_mul_lat", lat, 10);
    chk("w8_mul_res", res8, 8'h00);
    chk("w8_mul_nzcv", {n8, z8, c8, v8}, 4'b0110);
    run(1, 4'b1111, 16'h00A5, 16'h005A, lat);
    chk("w8_unk_lat", lat, 2);
    chk("w8_unk_res", res8, 8'h00);
    chk("w8_unk_nzcv", {n8, z8, c8, v8}, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
